execute_stage_p: RTL and testbench

Parametrised Execute stage for the pipelined core. It sits between the decode/register-read stage and the memory stage. It executes all 16 ISA opcodes and resolves branches against a registered ZF/GF/LF flag set. Shifts run on an iterative multi-cycle shifter. A valid/ready handshake stalls upstream, and a synchronous flush squashes in-flight work.

---
 rtl/execute_stage_p.sv | 199 +++++++++++++++++++
 tb/tb_execute_stage_p.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage_p.sv
`default_nettype none
// ============================================================================
// Module   : execute_stage_p
// Brief    : Pipelined execute stage with ALU, flag-based branches, iterative
//            shifter and a valid/ready output register.
// Revision : 1.0 - initial release
// ============================================================================
module execute_stage_p #(
  parameter int DATA_W     = 16,
  parameter int IMM_W      = 7,
  parameter int REG_IDX_W  = 5,
  parameter int SHIFT_STEP = 1,
  parameter bit SIGNED_CMP = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           opcode,
  input  logic [REG_IDX_W-1:0] dest_index_in,
  input  logic [DATA_W-1:0]    reg1_data,
  input  logic [DATA_W-1:0]    reg2_data,
  input  logic [DATA_W-1:0]    npc,
  input  logic [IMM_W-1:0]     immediate,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           opcode_out,
  output logic [REG_IDX_W-1:0] dest_index_out,
  output logic [DATA_W-1:0]    result_out,
  output logic [DATA_W-1:0]    store_data_out,
  output logic                 dest_reg_write_en,
  output logic                 branch_taken,
  output logic [DATA_W-1:0]    target,
  output logic                 ZF,
  output logic                 GF,
  output logic                 LF,
  output logic                 busy
);

  localparam int c_AMT_W  = $clog2(DATA_W);
  localparam int c_STEP_W = c_AMT_W + 1;
  localparam logic [c_STEP_W-1:0] c_STEP = c_STEP_W'(SHIFT_STEP);

  localparam logic [3:0] c_OP_SUB    = 4'h1;
  localparam logic [3:0] c_OP_ADD    = 4'h2;
  localparam logic [3:0] c_OP_ADDI   = 4'h3;
  localparam logic [3:0] c_OP_SHLLI  = 4'h4;
  localparam logic [3:0] c_OP_SHRLI  = 4'h5;
  localparam logic [3:0] c_OP_JUMP   = 4'h6;
  localparam logic [3:0] c_OP_JUMPL  = 4'h7;
  localparam logic [3:0] c_OP_JUMPG  = 4'h8;
  localparam logic [3:0] c_OP_JUMPE  = 4'h9;
  localparam logic [3:0] c_OP_JUMPNE = 4'hA;
  localparam logic [3:0] c_OP_CMP    = 4'hB;
  localparam logic [3:0] c_OP_LOAD   = 4'hC;
  localparam logic [3:0] c_OP_LOADI  = 4'hD;
  localparam logic [3:0] c_OP_STORE  = 4'hE;
  localparam logic [3:0] c_OP_MOV    = 4'hF;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  state_t                 r_state;
  logic                   r_out_valid, r_we, r_br, r_zf, r_gf, r_lf, r_shift_left;
  logic [3:0]             r_opcode;
  logic [REG_IDX_W-1:0]   r_dest, r_pend_dest;
  logic [DATA_W-1:0]      r_result, r_store, r_target, r_pend_target, r_shift_val;
  logic [c_AMT_W-1:0]     r_shift_rem;

  logic [DATA_W-1:0]      w_imm_sext, w_imm_zext, w_target, w_result, w_store, w_shift_next;
  logic [c_AMT_W-1:0]     w_amt, w_rem_next;
  logic [c_STEP_W-1:0]    w_step;
  logic                   w_we, w_br, w_eq, w_gt, w_lt, w_out_free, w_accept, w_start_shift;

  assign w_imm_sext    = {{(DATA_W-IMM_W){immediate[IMM_W-1]}}, immediate};
  assign w_imm_zext    = {{(DATA_W-IMM_W){1'b0}}, immediate};
  assign w_target      = npc + w_imm_sext;
  assign w_amt         = immediate[c_AMT_W-1:0];
  assign w_start_shift = ((opcode == c_OP_SHLLI) || (opcode == c_OP_SHRLI)) && (w_amt != '0);
  assign w_out_free    = !r_out_valid || out_ready;
  assign in_ready      = rst_n && !flush && (r_state == S_IDLE) && w_out_free;
  assign w_accept      = in_valid && in_ready;

  assign w_eq = (reg1_data == reg2_data);
  assign w_gt = SIGNED_CMP ? ($signed(reg1_data) > $signed(reg2_data)) : (reg1_data > reg2_data);
  assign w_lt = SIGNED_CMP ? ($signed(reg1_data) < $signed(reg2_data)) : (reg1_data < reg2_data);

  // The last step is clipped so a step wider than the remainder never overshoots.
  assign w_step       = ({1'b0, r_shift_rem} < c_STEP) ? {1'b0, r_shift_rem} : c_STEP;
  assign w_shift_next = r_shift_left ? (r_shift_val << w_step) : (r_shift_val >> w_step);
  assign w_rem_next   = r_shift_rem - w_step[c_AMT_W-1:0];

  always_comb begin
    w_result = '0;
    w_store  = '0;
    w_we     = 1'b0;
    w_br     = 1'b0;
    case (opcode)
      c_OP_SUB:                 begin w_result = reg1_data - reg2_data;  w_we = 1'b1; end
      c_OP_ADD:                 begin w_result = reg1_data + reg2_data;  w_we = 1'b1; end
      c_OP_ADDI, c_OP_LOAD:     begin w_result = reg1_data + w_imm_sext; w_we = 1'b1; end
      c_OP_SHLLI, c_OP_SHRLI:   begin w_result = reg1_data;              w_we = 1'b1; end
      c_OP_LOADI:               begin w_result = w_imm_zext;             w_we = 1'b1; end
      c_OP_MOV:                 begin w_result = reg1_data;              w_we = 1'b1; end
      c_OP_STORE:               begin w_result = reg1_data + w_imm_sext; w_store = reg2_data; end
      c_OP_JUMP:                w_br = 1'b1;
      c_OP_JUMPL:               w_br = r_lf;
      c_OP_JUMPG:               w_br = r_gf;
      c_OP_JUMPE:               w_br = r_zf;
      c_OP_JUMPNE:              w_br = !r_zf;
      default:                  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_out_valid   <= 1'b0;
      r_opcode      <= '0;
      r_dest        <= '0;
      r_result      <= '0;
      r_store       <= '0;
      r_we          <= 1'b0;
      r_br          <= 1'b0;
      r_target      <= '0;
      r_zf          <= 1'b0;
      r_gf          <= 1'b0;
      r_lf          <= 1'b0;
      r_shift_val   <= '0;
      r_shift_rem   <= '0;
      r_shift_left  <= 1'b0;
      r_pend_dest   <= '0;
      r_pend_target <= '0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_br        <= 1'b0;
      r_we        <= 1'b0;
    end else if (r_state == S_SHIFT) begin
      r_shift_val <= w_shift_next;
      r_shift_rem <= w_rem_next;
      // A finished shift parks here until the output register is free.
      if ((w_rem_next == '0) && w_out_free) begin
        r_state     <= S_IDLE;
        r_out_valid <= 1'b1;
        r_opcode    <= r_shift_left ? c_OP_SHLLI : c_OP_SHRLI;
        r_dest      <= r_pend_dest;
        r_result    <= w_shift_next;
        r_store     <= '0;
        r_we        <= 1'b1;
        r_br        <= 1'b0;
        r_target    <= r_pend_target;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      if (w_start_shift) begin
        r_state       <= S_SHIFT;
        r_out_valid   <= 1'b0;
        r_shift_val   <= reg1_data;
        r_shift_rem   <= w_amt;
        r_shift_left  <= (opcode == c_OP_SHLLI);
        r_pend_dest   <= dest_index_in;
        r_pend_target <= w_target;
      end else begin
        r_out_valid <= 1'b1;
        r_opcode    <= opcode;
        r_dest      <= dest_index_in;
        r_result    <= w_result;
        r_store     <= w_store;
        r_we        <= w_we;
        r_br        <= w_br;
        r_target    <= w_target;
      end
      if (opcode == c_OP_CMP) begin
        r_zf <= w_eq;
        r_gf <= w_gt;
        r_lf <= w_lt;
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid         = r_out_valid;
  assign opcode_out        = r_opcode;
  assign dest_index_out    = r_dest;
  assign result_out        = r_result;
  assign store_data_out    = r_store;
  assign dest_reg_write_en = r_we;
  assign branch_taken      = r_br;
  assign target            = r_target;
  assign ZF                = r_zf;
  assign GF                = r_gf;
  assign LF                = r_lf;
  assign busy              = (r_state == S_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_execute_stage_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_stage_p
// Brief    : Vector table plus scoreboard bench for execute_stage_p.
// Revision : 1.0 - initial release
// ============================================================================
module tb_execute_stage_p;

  localparam logic [3:0] c_NOP = 4'h0, c_SUB = 4'h1, c_ADD = 4'h2, c_ADDI = 4'h3;
  localparam logic [3:0] c_SHL = 4'h4, c_SHR = 4'h5, c_JMP = 4'h6, c_JL = 4'h7;
  localparam logic [3:0] c_JG = 4'h8, c_JE = 4'h9, c_JNE = 4'hA, c_CMP = 4'hB;
  localparam logic [3:0] c_LD = 4'hC, c_LDI = 4'hD, c_ST = 4'hE, c_MOV = 4'hF;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  opcode, opcode_out;
  logic [4:0]  dest_index_in, dest_index_out;
  logic [15:0] reg1_data, reg2_data, npc, result_out, store_data_out, target;
  logic [6:0]  immediate;
  logic        dest_reg_write_en, branch_taken, ZF, GF, LF, busy;

  always #5 clk = ~clk;

  execute_stage_p dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .dest_index_in(dest_index_in), .reg1_data(reg1_data),
    .reg2_data(reg2_data), .npc(npc), .immediate(immediate), .out_valid(out_valid),
    .out_ready(out_ready), .opcode_out(opcode_out), .dest_index_out(dest_index_out),
    .result_out(result_out), .store_data_out(store_data_out),
    .dest_reg_write_en(dest_reg_write_en), .branch_taken(branch_taken), .target(target),
    .ZF(ZF), .GF(GF), .LF(LF), .busy(busy)
  );

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  dest;
    logic [15:0] res;
    logic [15:0] st;
    logic        we;
    logic        br;
    logic [15:0] tgt;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  dest;
    logic [15:0] r1;
    logic [15:0] r2;
    logic [15:0] pc;
    logic [6:0]  imm;
    logic [15:0] res;
    logic [15:0] st;
    logic        we;
    logic        br;
    logic [15:0] tgt;
    logic        cf;
    logic        zf;
    logic        gf;
    logic        lf;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t vt[23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every transfer out of the stage is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got result %0h expected no output", result_out);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_opcode", {28'h0, opcode_out}, {28'h0, mon_e.op});
        chk("sb_dest", {27'h0, dest_index_out}, {27'h0, mon_e.dest});
        chk("sb_result", {16'h0, result_out}, {16'h0, mon_e.res});
        chk("sb_store", {16'h0, store_data_out}, {16'h0, mon_e.st});
        chk("sb_we", {31'h0, dest_reg_write_en}, {31'h0, mon_e.we});
        chk("sb_branch", {31'h0, branch_taken}, {31'h0, mon_e.br});
        chk("sb_target", {16'h0, target}, {16'h0, mon_e.tgt});
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [4:0] d, input logic [15:0] r1,
                       input logic [15:0] r2, input logic [15:0] pc, input logic [6:0] imm,
                       input exp_t e);
    int n;
    opcode = op; dest_index_in = d; reg1_data = r1; reg2_data = r2;
    npc = pc; immediate = imm; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got in_ready %0b expected 1", in_ready);
        break;
      end
    end
    if (n <= 200) sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid === 1'b1) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", {31'h0, (n < 100)}, 32'h1);
  endtask

  task automatic wait_busy(input string name, input int exp_cycles);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      chk({name, "_in_ready_low"}, {31'h0, in_ready}, 32'h0);
      n++;
      @(posedge clk);
      #1;
    end
    chk({name, "_latency"}, n, exp_cycles);
    chk({name, "_out_valid"}, {31'h0, out_valid}, 32'h1);
  endtask

  initial begin
    exp_t e;
    vt[0]  = '{c_SUB,  5'd2, 16'h000A, 16'h0003, 16'h0000, 7'h00, 16'h0007, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{c_ADD,  5'd2, 16'h000A, 16'h0005, 16'h0000, 7'h00, 16'h000F, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{c_ADDI, 5'd2, 16'h000A, 16'h0000, 16'h0000, 7'h07, 16'h0011, 16'h0000, 1'b1, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{c_ADDI, 5'd2, 16'h000A, 16'h0000, 16'h0000, 7'h7F, 16'h0009, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{c_LDI,  5'd3, 16'h1111, 16'h0000, 16'h0000, 7'h7F, 16'h007F, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{c_MOV,  5'd4, 16'hABCD, 16'h0000, 16'h0000, 7'h00, 16'hABCD, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{c_LD,   5'd5, 16'h0100, 16'h0000, 16'h0000, 7'h7C, 16'h00FC, 16'h0000, 1'b1, 1'b0, 16'hFFFC, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{c_ST,   5'd0, 16'h0200, 16'hBEEF, 16'h0000, 7'h03, 16'h0203, 16'hBEEF, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{c_NOP,  5'd0, 16'h0000, 16'h0000, 16'h0040, 7'h00, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0040, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{c_SHL,  5'd6, 16'h1234, 16'h0000, 16'h0000, 7'h10, 16'h1234, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[10] = '{c_SUB,  5'd1, 16'h0000, 16'h0001, 16'h0000, 7'h00, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[11] = '{c_CMP,  5'd0, 16'hFFFF, 16'h0001, 16'h0000, 7'h00, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[12] = '{c_JL,   5'd0, 16'h0000, 16'h0000, 16'h0014, 7'h7C, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[13] = '{c_JE,   5'd0, 16'h0000, 16'h0000, 16'h0014, 7'h7C, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[14] = '{c_JG,   5'd0, 16'h0000, 16'h0000, 16'h0014, 7'h7C, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[15] = '{c_JNE,  5'd0, 16'h0000, 16'h0000, 16'h0014, 7'h7C, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[16] = '{c_CMP,  5'd0, 16'h0005, 16'h0005, 16'h0000, 7'h00, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[17] = '{c_JE,   5'd0, 16'h0000, 16'h0000, 16'h0014, 7'h7C, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[18] = '{c_JNE,  5'd0, 16'h0000, 16'h0000, 16'h0014, 7'h7C, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[19] = '{c_CMP,  5'd0, 16'h0007, 16'h0003, 16'h0000, 7'h00, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[20] = '{c_JG,   5'd0, 16'h0000, 16'h0000, 16'h0014, 7'h7C, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[21] = '{c_JMP,  5'd0, 16'h0000, 16'h0000, 16'h0030, 7'h05, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0035, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[22] = '{c_ADD,  5'd9, 16'hFFFF, 16'h0001, 16'h0000, 7'h00, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    opcode = 4'h0; dest_index_in = 5'd0; reg1_data = 16'h0; reg2_data = 16'h0;
    npc = 16'h0; immediate = 7'h0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_flags", {29'h0, ZF, GF, LF}, 32'h0);
    chk("rst_result", {16'h0, result_out}, 32'h0);
    chk("rst_target", {16'h0, target}, 32'h0);
    chk("rst_we_br", {30'h0, dest_reg_write_en, branch_taken}, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rst_release_in_ready", {31'h0, in_ready}, 32'h1);

    for (int i = 0; i < 23; i++) begin
      e = '{vt[i].op, vt[i].dest, vt[i].res, vt[i].st, vt[i].we, vt[i].br, vt[i].tgt};
      issue(vt[i].op, vt[i].dest, vt[i].r1, vt[i].r2, vt[i].pc, vt[i].imm, e);
      if (vt[i].cf) chk("cmp_flags", {29'h0, ZF, GF, LF}, {29'h0, vt[i].zf, vt[i].gf, vt[i].lf});
    end
    drain();

    // Multi-cycle shifts: one bit per edge.
    e = '{c_SHL, 5'd6, 16'h0060, 16'h0000, 1'b1, 1'b0, 16'h0005};
    issue(c_SHL, 5'd6, 16'h0003, 16'h0000, 16'h0000, 7'h05, e);
    wait_busy("shl5", 5);
    chk("shl5_result", {16'h0, result_out}, 32'h0060);
    e = '{c_SHR, 5'd7, 16'h0001, 16'h0000, 1'b1, 1'b0, 16'h000F};
    issue(c_SHR, 5'd7, 16'h8000, 16'h0000, 16'h0000, 7'h0F, e);
    wait_busy("shr15", 15);
    chk("shr15_result", {16'h0, result_out}, 32'h0001);
    drain();

    // Backpressure: held MOV stays stable while a queued ADD waits.
    out_ready = 1'b0;
    e = '{c_MOV, 5'd7, 16'hABCD, 16'h0000, 1'b1, 1'b0, 16'h0000};
    issue(c_MOV, 5'd7, 16'hABCD, 16'h0000, 16'h0000, 7'h00, e);
    opcode = c_ADD; dest_index_in = 5'd8; reg1_data = 16'h0001; reg2_data = 16'h0002;
    npc = 16'h0; immediate = 7'h0; in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("bp_hold_valid", {31'h0, out_valid}, 32'h1);
      chk("bp_hold_result", {16'h0, result_out}, 32'hABCD);
      chk("bp_hold_dest", {27'h0, dest_index_out}, 32'h7);
      chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
    end
    out_ready = 1'b1;
    e = '{c_ADD, 5'd8, 16'h0003, 16'h0000, 1'b1, 1'b0, 16'h0000};
    issue(c_ADD, 5'd8, 16'h0001, 16'h0002, 16'h0000, 7'h00, e);
    chk("bp_same_edge_result", {16'h0, result_out}, 32'h0003);
    chk("bp_same_edge_valid", {31'h0, out_valid}, 32'h1);
    drain();

    // Flush on the second shifting edge with a competing instruction offered.
    e = '{c_SHL, 5'd6, 16'h0060, 16'h0000, 1'b1, 1'b0, 16'h0005};
    issue(c_SHL, 5'd6, 16'h0003, 16'h0000, 16'h0000, 7'h05, e);
    @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; opcode = c_CMP; reg1_data = 16'h0001; reg2_data = 16'h0009;
    #1;
    chk("flush_in_ready", {31'h0, in_ready}, 32'h0);
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    chk("flush_out_valid", {31'h0, out_valid}, 32'h0);
    chk("flush_busy", {31'h0, busy}, 32'h0);
    chk("flush_flags", {29'h0, ZF, GF, LF}, 32'h2);
    chk("flush_we_br", {30'h0, dest_reg_write_en, branch_taken}, 32'h0);
    repeat (8) @(posedge clk);
    #1;
    chk("flush_nothing_accepted", {30'h0, out_valid, busy}, 32'h0);
    e = '{c_LDI, 5'd1, 16'h007F, 16'h0000, 1'b1, 1'b0, 16'hFFFF};
    issue(c_LDI, 5'd1, 16'h0000, 16'h0000, 16'h0000, 7'h7F, e);
    chk("post_flush_loadi", {16'h0, result_out}, 32'h007F);
    drain();
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
